// File: rtl/pll_reset_ctrl.sv
// PLL reset sequencer: pulses pll_rst, waits for a stable synchronized lock, then releases sys_rst.
// Define PLL_RST_CTRL_STATS_EN to add the saturating lock_losses counter and port.
module pll_reset_ctrl #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 4096,
    parameter int STABLE_CYCLES = 256,
    parameter int MAX_RETRIES   = 3
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic       fail
`ifdef PLL_RST_CTRL_STATS_EN
    ,
    output logic [7:0] lock_losses
`endif
);
    localparam int MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_C = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
    localparam int CW    = $clog2(MAX_C) + 1;
    localparam int RW    = $clog2(MAX_RETRIES + 1) + 1;

    localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] LOCK_LAST   = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_MAX   = RW'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_PLL_RST,
        ST_WAIT_LOCK,
        ST_STABLE,
        ST_RUN,
        ST_FAIL
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [RW-1:0]   retries_q, retries_d;
    logic            sync1_q, locked_s_q;
    logic            pll_rst_q, pll_rst_d;
    logic            sys_rst_q, sys_rst_d;
    logic            ready_q, ready_d;
    logic            fail_q, fail_d;
`ifdef PLL_RST_CTRL_STATS_EN
    logic [7:0]      ll_q, ll_d;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        retries_d = retries_q;
`ifdef PLL_RST_CTRL_STATS_EN
        ll_d      = ll_q;
`endif
        case (state_q)
            ST_PLL_RST: begin
                if (cnt_q == RST_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT_LOCK;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_WAIT_LOCK: begin
                if (locked_s_q) begin
                    cnt_d   = '0;
                    state_d = ST_STABLE;
                end else if (cnt_q == LOCK_LAST) begin
                    if (retries_q == RETRY_MAX) begin
                        state_d = ST_FAIL;
                    end else begin
                        retries_d = retries_q + RW'(1);
                        cnt_d     = '0;
                        state_d   = ST_PLL_RST;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_STABLE: begin
                // A dropout restarts the lock window without spending a retry
                if (!locked_s_q) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT_LOCK;
                end else if (cnt_q == STABLE_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_RUN: begin
                retries_d = '0;
                if (!locked_s_q) begin
                    cnt_d   = '0;
                    state_d = ST_PLL_RST;
`ifdef PLL_RST_CTRL_STATS_EN
                    if (ll_q != 8'hFF) ll_d = ll_q + 8'd1;
`endif
                end
            end
            ST_FAIL: ;
            default: begin
                cnt_d   = '0;
                state_d = ST_PLL_RST;
            end
        endcase

        // Outputs decode the next state so they change on the transition edge
        pll_rst_d = (state_d == ST_PLL_RST) || (state_d == ST_FAIL);
        sys_rst_d = (state_d != ST_RUN);
        ready_d   = (state_d == ST_RUN);
        fail_d    = (state_d == ST_FAIL);
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q    <= ST_PLL_RST;
            cnt_q      <= '0;
            retries_q  <= '0;
            sync1_q    <= 1'b0;
            locked_s_q <= 1'b0;
            pll_rst_q  <= 1'b1;
            sys_rst_q  <= 1'b1;
            ready_q    <= 1'b0;
            fail_q     <= 1'b0;
`ifdef PLL_RST_CTRL_STATS_EN
            ll_q       <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            retries_q  <= retries_d;
            sync1_q    <= pll_locked;
            locked_s_q <= sync1_q;
            pll_rst_q  <= pll_rst_d;
            sys_rst_q  <= sys_rst_d;
            ready_q    <= ready_d;
            fail_q     <= fail_d;
`ifdef PLL_RST_CTRL_STATS_EN
            ll_q       <= ll_d;
`endif
        end
    end

    assign pll_rst = pll_rst_q;
    assign sys_rst = sys_rst_q;
    assign ready   = ready_q;
    assign fail    = fail_q;
`ifdef PLL_RST_CTRL_STATS_EN
    assign lock_losses = ll_q;
`endif
endmodule
